// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces press and
// release on scan_tick samples, and hands accepted keys to a consumer.
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_tick,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic [15:0] data_out,
    output logic        overflow
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    row_idx, row_idx_n;
    logic [3:0]    row_pat, row_pat_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n;
    logic [15:0]   data_out_n;
    logic          overflow_n;
    logic          accept;
    logic [3:0]    mapped;

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] v;
        case ({r, c})
            4'b00_00: v = 4'h1;
            4'b00_01: v = 4'h2;
            4'b00_10: v = 4'h3;
            4'b00_11: v = 4'hA;
            4'b01_00: v = 4'h4;
            4'b01_01: v = 4'h5;
            4'b01_10: v = 4'h6;
            4'b01_11: v = 4'hB;
            4'b10_00: v = 4'h7;
            4'b10_01: v = 4'h8;
            4'b10_10: v = 4'h9;
            4'b10_11: v = 4'hC;
            4'b11_00: v = 4'h0;
            4'b11_01: v = 4'hF;
            4'b11_10: v = 4'hE;
            default:  v = 4'hD;
        endcase
        return v;
    endfunction

    assign col    = ~(4'b0001 << col_idx);
    assign mapped = map_key(row_idx, col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            row_pat   <= 4'hF;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            data_out  <= 16'h0000;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            row_pat   <= row_pat_n;
            cnt       <= cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            data_out  <= data_out_n;
            overflow  <= overflow_n;
        end
    end

    // The column stays frozen from detection until the release is debounced,
    // so col_idx doubles as the latched column of the pending key.
    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        row_idx_n = row_idx;
        row_pat_n = row_pat;
        cnt_n     = cnt;
        accept    = 1'b0;

        if (scan_tick) begin
            case (state)
                SCAN: begin
                    if (row == 4'hF) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        row_idx_n = lowest_low(row);
                        row_pat_n = row;
                        cnt_n     = CW'(1);
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row == row_pat) begin
                        if (cnt >= CNT_LAST) begin
                            accept  = 1'b1;
                            cnt_n   = '0;
                            state_n = WAIT_RELEASE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n     = '0;
                        col_idx_n = col_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
                WAIT_RELEASE: begin
                    if (row == 4'hF) begin
                        if (cnt >= CNT_LAST) begin
                            cnt_n     = '0;
                            col_idx_n = col_idx + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            endcase
        end
    end

    // A new key wins over a same-edge acknowledge; only an unacked overwrite
    // marks overflow.
    always_comb begin
        key_code_n  = key_code;
        key_valid_n = key_valid;
        data_out_n  = data_out;
        overflow_n  = overflow;

        if (accept) begin
            key_code_n  = mapped;
            data_out_n  = {data_out[11:0], mapped};
            key_valid_n = 1'b1;
            if (key_valid && !key_ack) begin
                overflow_n = 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid_n = 1'b0;
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4: consecutive scan_tick samples needed to accept a press or a release (legal range 2..15).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 scan_tick  input  1  one-clk-cycle enable pulse from the clock divider; paces column advance and row sampling.
REQ-005 row  input  [3:0]  keypad rows, active-low, externally pulled up.
REQ-006 col  output  [3:0]  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  [3:0]  hex value of the last accepted key.
REQ-008 key_valid  output  1  high while key_code holds an unacknowledged key.
REQ-009 key_ack  input  1  consumer acknowledge; only effective while key_valid=1.
REQ-010 data_out  output  [15:0]  last four accepted keys, newest in [3:0], for the seg_display data_in.
REQ-011 overflow  output  1  sticky flag: a key was accepted while the previous key was still unacknowledged.

Function
REQ-012 FSM states SCAN, DEBOUNCE, WAIT_RELEASE; col drive is col_idx 0..3 -> 1110, 1101, 1011, 0111.
REQ-013 Row sampling occurs only on clk edges where scan_tick=1; row is sampled for the currently driven column before any column change.
REQ-014 SCAN, scan_tick, row=1111: col_idx advances by 1, wrapping 3 -> 0.
REQ-015 SCAN, scan_tick, any row bit low: latch col_idx, latch the lowest-index low row bit as row_idx, set debounce count to 1, go to DEBOUNCE; col frozen.
REQ-016 DEBOUNCE, scan_tick, row equals the latched pattern: increment count; on reaching DEBOUNCE_TICKS, accept the key and go to WAIT_RELEASE.
REQ-017 DEBOUNCE, scan_tick, row differs from the latched pattern: clear count, return to SCAN, advance col_idx; no key output.
REQ-018 Key map (row_idx, col_idx 0..3): row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D.
REQ-019 Accept, registered on the same edge: key_code <= mapped value; data_out <= {data_out[11:0], mapped value}; key_valid <= 1.
REQ-020 Latency: key_valid rises on the edge of the DEBOUNCE_TICKS-th consecutive matching scan_tick sample.
REQ-021 WAIT_RELEASE: col frozen; count consecutive scan_tick samples with row=1111; any low bit clears the count.
REQ-022 WAIT_RELEASE, count reaches DEBOUNCE_TICKS: go to SCAN, advance col_idx; a held key produces exactly one accept (no auto-repeat).
REQ-023 Handshake: key_ack=1 while key_valid=1 clears key_valid on that edge; key_ack while key_valid=0 is ignored.
REQ-024 Accept with key_valid=1 and key_ack=0: overflow <= 1, key_code overwritten, key_valid stays 1.
REQ-025 Accept and key_ack on the same edge: key_valid stays 1 with the new code, overflow unchanged.
REQ-026 overflow clears only on reset.
REQ-027 Debounce counters saturate and never wrap; width is clog2(DEBOUNCE_TICKS+1).
REQ-028 Clock edges without scan_tick leave FSM state, col_idx and counters unchanged.

Reset
REQ-029 While rst=1, asynchronously: state=SCAN, col_idx=0 (col=1110), counters=0, key_code=0, key_valid=0, data_out=16'h0000, overflow=0.
REQ-030 rst asserted mid-DEBOUNCE or mid-WAIT_RELEASE discards the pending key; the first post-reset scan_tick samples column 0.

Verification
REQ-031 No key pressed, 8 scan_ticks -> col sequence 1110,1101,1011,0111,1110,...; key_valid stays 0.
REQ-032 Key "5" (row1 low while col=1101) held 4 ticks, then released -> key_code=5, key_valid=1, data_out=0x0005; no second accept while held 20 more ticks.
REQ-033 Keys 1,2,3,4 pressed and released, each acked -> data_out=0x1234, overflow=0.
REQ-034 Row bounce of 2 matching ticks then 1 mismatching tick -> returns to SCAN, col advances, key_valid stays 0.
REQ-035 Keys "A" then "D" accepted without ack -> key_code=D, key_valid=1, overflow=1; ack -> key_valid=0, overflow stays 1.
REQ-036 rst pulsed in WAIT_RELEASE with key_valid=1 -> all outputs reset values, col=1110 immediately, without waiting for a clk edge.
